// File: rtl/vga_sync_gen.sv
// VGA vertical counter and sync/visibility decode driven by an upstream horizontal counter.
// All outputs are registered and describe the (h_count, v_count) pair sampled at the same edge.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE_END = 639,
    parameter int unsigned H_SYNC_START  = 656,
    parameter int unsigned H_SYNC_END    = 751,
    parameter int unsigned V_VISIBLE_END = 479,
    parameter int unsigned V_SYNC_START  = 490,
    parameter int unsigned V_SYNC_END    = 491,
    parameter int unsigned V_END         = 524
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] h_count,
    input  logic        enable_v,
    output logic [15:0] v_count,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start
);

    localparam logic [15:0] HVisEnd   = 16'(H_VISIBLE_END);
    localparam logic [15:0] HSyncSt   = 16'(H_SYNC_START);
    localparam logic [15:0] HSyncEnd  = 16'(H_SYNC_END);
    localparam logic [15:0] VVisEnd   = 16'(V_VISIBLE_END);
    localparam logic [15:0] VSyncSt   = 16'(V_SYNC_START);
    localparam logic [15:0] VSyncEnd  = 16'(V_SYNC_END);
    localparam logic [15:0] VEnd      = 16'(V_END);

    logic [15:0] v_count_q, v_count_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        frame_start_q, frame_start_d;

    always_comb begin
        v_count_d = v_count_q;
        if (enable_v) begin
            // Also recovers from any out-of-range line value.
            v_count_d = (v_count_q >= VEnd) ? 16'd0 : v_count_q + 16'd1;
        end
    end

    always_comb begin
        hsync_n_d     = !((h_count >= HSyncSt) && (h_count <= HSyncEnd));
        vsync_n_d     = !((v_count_q >= VSyncSt) && (v_count_q <= VSyncEnd));
        video_on_d    = (h_count <= HVisEnd) && (v_count_q <= VVisEnd);
        pixel_x_d     = video_on_d ? h_count[9:0] : 10'd0;
        pixel_y_d     = video_on_d ? v_count_q[9:0] : 10'd0;
        frame_start_d = (h_count == 16'd0) && (v_count_q == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_count_q     <= 16'd0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            v_count_q     <= v_count_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign v_count     = v_count_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: driver pushes expected outputs from an arithmetic
// timing model, a monitor pops and compares one entry per clock.
module tb_vga_sync_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] h_count;
    logic        enable_v;
    logic [15:0] v_count;
    logic        hsync_n, vsync_n, video_on, frame_start;
    logic [9:0]  pixel_x, pixel_y;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        fs;
    } exp_t;

    exp_t        q[$];
    int unsigned model_v = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk         (clk),
        .reset       (reset),
        .h_count     (h_count),
        .enable_v    (enable_v),
        .v_count     (v_count),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line counting and decode are taken directly from the VGA timing numbers.
    task automatic drive(input logic [15:0] h, input logic en, input logic rst);
        exp_t e;
        @(negedge clk);
        h_count  = h;
        enable_v = en;
        reset    = rst;
        if (rst) begin
            model_v = 0;
            e = '{v: 16'd0, hs: 1'b1, vs: 1'b1, vid: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0};
        end else begin
            e.vid = (h <= 639) && (model_v <= 479);
            e.hs  = !(h >= 656 && h <= 751);
            e.vs  = !(model_v >= 490 && model_v <= 491);
            e.px  = e.vid ? h[9:0] : 10'd0;
            e.py  = e.vid ? 10'(model_v) : 10'd0;
            e.fs  = (h == 0) && (model_v == 0);
            if (en) model_v = (model_v >= 524) ? 0 : model_v + 1;
            e.v   = 16'(model_v);
        end
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("v_count", 32'(v_count), 32'(e.v));
                chk("hsync_n", 32'(hsync_n), 32'(e.hs));
                chk("vsync_n", 32'(vsync_n), 32'(e.vs));
                chk("video_on", 32'(video_on), 32'(e.vid));
                chk("pixel_x", 32'(pixel_x), 32'(e.px));
                chk("pixel_y", 32'(pixel_y), 32'(e.py));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin
        logic [15:0] h;
        int          waited;
        reset = 1'b1;
        h_count = 16'd0;
        enable_v = 1'b0;

        // Reset for 3 cycles, release with h=0: first frame_start follows.
        repeat (3) drive(16'd0, 1'b0, 1'b1);
        drive(16'd0, 1'b0, 1'b0);

        // Advance to line 10 and sweep a full line.
        repeat (10) drive(16'(800 + $urandom_range(0, 50)), 1'b1, 1'b0);
        for (int i = 0; i < 800; i++) drive(16'(i), 1'b0, 1'b0);

        // Full frame of enable pulses from line 0, including wrap.
        drive(16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 526; i++) drive(16'd800, 1'b1, 1'b0);

        // Last visible line into first blank line.
        drive(16'd0, 1'b0, 1'b1);
        repeat (479) drive(16'd700, 1'b1, 1'b0);
        drive(16'd100, 1'b1, 1'b0);
        drive(16'd100, 1'b0, 1'b0);

        // Reset wins over enable_v mid-frame.
        drive(16'd0, 1'b0, 1'b1);
        repeat (300) drive(16'd799, 1'b1, 1'b0);
        drive(16'd5, 1'b1, 1'b1);
        drive(16'd5, 1'b0, 1'b0);

        // Out-of-range columns, including ones that alias into range if truncated.
        drive(16'd900, 1'b0, 1'b0);
        drive(16'd1124, 1'b0, 1'b0);
        drive(16'd1680, 1'b0, 1'b0);
        drive(16'hffff, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       h = 16'($urandom);
                1:       h = 16'd0;
                default: h = 16'($urandom_range(0, 1100));
            endcase
            drive(h, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end

        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE_END, default 639, giving the last visible pixel column.
REQ-002 The block SHALL have parameter H_SYNC_START, default 656, giving the first column with hsync asserted.
REQ-003 The block SHALL have parameter H_SYNC_END, default 751, giving the last column with hsync asserted.
REQ-004 The block SHALL have parameter V_VISIBLE_END, default 479, giving the last visible line.
REQ-005 The block SHALL have parameter V_SYNC_START, default 490, giving the first line with vsync asserted.
REQ-006 The block SHALL have parameter V_SYNC_END, default 491, giving the last line with vsync asserted.
REQ-007 The block SHALL have parameter V_END, default 524, giving the last line of a frame.
REQ-008 The block SHALL have port clk, input, 1 bit: the pixel clock, with all logic on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-010 The block SHALL have port h_count, input, 16 bits: the current column, driven by the upstream horizontal counter.
REQ-011 The block SHALL have port enable_v, input, 1 bit: the end-of-line strobe from the upstream horizontal counter, high for one cycle.
REQ-012 The block SHALL have port v_count, output, 16 bits: the current line, registered.
REQ-013 The block SHALL have port hsync_n, output, 1 bit: horizontal sync, active-low, registered.
REQ-014 The block SHALL have port vsync_n, output, 1 bit: vertical sync, active-low, registered.
REQ-015 The block SHALL have port video_on, output, 1 bit: high when the delayed pixel is visible, registered.
REQ-016 The block SHALL have port pixel_x, output, 10 bits: the column of the delayed pixel, registered.
REQ-017 The block SHALL have port pixel_y, output, 10 bits: the line of the delayed pixel, registered.
REQ-018 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse marking the first pixel of a frame, registered.

Function
REQ-019 The block SHALL hold v_count unchanged when enable_v=0 at a clock edge.
REQ-020 When enable_v=1 and v_count<V_END, the block SHALL set v_count to v_count+1 at that edge.
REQ-021 When enable_v=1 and v_count==V_END, the block SHALL set v_count to 0 at that edge (wrap).
REQ-022 When v_count>V_END from any cause, the block SHALL set v_count to 0 on the next enable_v.
REQ-023 The block SHALL compute every registered output at edge k from the pair (h_count, v_count) sampled at edge k, giving 1-cycle latency.
REQ-024 The block SHALL drive hsync_n low iff H_SYNC_START <= h_count <= H_SYNC_END, and high otherwise.
REQ-025 The block SHALL drive vsync_n low iff V_SYNC_START <= v_count <= V_SYNC_END, and high otherwise.
REQ-026 The block SHALL drive video_on=1 iff h_count <= H_VISIBLE_END and v_count <= V_VISIBLE_END.
REQ-027 When video_on=1, the block SHALL set pixel_x=h_count[9:0] and pixel_y=v_count[9:0].
REQ-028 When video_on=0, the block SHALL force pixel_x and pixel_y to 0.
REQ-029 The block SHALL drive frame_start=1 for exactly one cycle when the sampled pair equals (0,0), and 0 otherwise.
REQ-030 The block SHALL treat any h_count beyond the sync range as blanking: video_on=0, hsync_n=1.
REQ-031 All comparisons SHALL be unsigned on 16 bits, with no truncation before comparing.

Reset
REQ-032 When reset=1 at an edge, the block SHALL set v_count=0, hsync_n=1, vsync_n=1, video_on=0, pixel_x=0, pixel_y=0 and frame_start=0.
REQ-033 Reset SHALL take priority over enable_v when both are high in the same cycle.
REQ-034 A mid-frame reset SHALL restart the frame at line 0.
REQ-035 After reset releases, the first frame_start SHALL occur one cycle after the pair (0,0) is first presented.

Verification
REQ-036 Bench case: reset held 3 cycles, then released with h_count=0 -> all outputs at reset values during reset; frame_start=1 on the cycle after release, and v_count=0.
REQ-037 Bench case: h_count swept 0..799 on line 10 -> video_on high on output cycles 1..640; hsync_n low on output cycles 657..752, i.e. exactly 96 cycles.
REQ-038 Bench case: 525 enable_v pulses from v_count=0 -> v_count reaches 524, then returns to 0; vsync_n low for lines 490..491 only.
REQ-039 Bench case: h_count=100 with v_count=479, then v_count=480 -> pixel_y=479 with video_on=1, then pixel_x=0, pixel_y=0, video_on=0.
REQ-040 Bench case: reset and enable_v high together at v_count=300 -> v_count=0 next cycle, not 301.
REQ-041 Bench case: h_count=900 (out of range) -> video_on=0, hsync_n=1, pixel_x=0.
